// File: rtl/fft64_stage_seq_if.sv
// Bundle of the sequencer's stream, butterfly and status signals.
// slave is the sequencer's view; master is the surrounding environment.
interface fft64_stage_seq_if #(
  parameter int unsigned DATA_WD = 16,
  parameter int unsigned PTS_LOG = 6
);
  logic                 dat_inp_vld_i;
  logic                 dat_inp_rdy_o;
  logic [DATA_WD-1:0]   dat_inp_re_i;
  logic [DATA_WD-1:0]   dat_inp_im_i;
  logic [DATA_WD-1:0]   dat_fft_1_re_o;
  logic [DATA_WD-1:0]   dat_fft_1_im_o;
  logic [DATA_WD-1:0]   dat_fft_2_re_o;
  logic [DATA_WD-1:0]   dat_fft_2_im_o;
  logic [PTS_LOG-2:0]   dat_wn_adr_o;
  logic [DATA_WD-1:0]   dat_fft_1_re_i;
  logic [DATA_WD-1:0]   dat_fft_1_im_i;
  logic [DATA_WD-1:0]   dat_fft_2_re_i;
  logic [DATA_WD-1:0]   dat_fft_2_im_i;
  logic                 dat_out_vld_o;
  logic                 dat_out_rdy_i;
  logic [DATA_WD-1:0]   dat_out_re_o;
  logic [DATA_WD-1:0]   dat_out_im_o;
  logic [PTS_LOG-1:0]   dat_out_idx_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  dat_inp_vld_i, dat_inp_re_i, dat_inp_im_i,
    input  dat_fft_1_re_i, dat_fft_1_im_i, dat_fft_2_re_i, dat_fft_2_im_i,
    input  dat_out_rdy_i,
    output dat_inp_rdy_o,
    output dat_fft_1_re_o, dat_fft_1_im_o, dat_fft_2_re_o, dat_fft_2_im_o, dat_wn_adr_o,
    output dat_out_vld_o, dat_out_re_o, dat_out_im_o, dat_out_idx_o,
    output busy_o, done_o
  );

  modport master (
    output dat_inp_vld_i, dat_inp_re_i, dat_inp_im_i,
    output dat_fft_1_re_i, dat_fft_1_im_i, dat_fft_2_re_i, dat_fft_2_im_i,
    output dat_out_rdy_i,
    input  dat_inp_rdy_o,
    input  dat_fft_1_re_o, dat_fft_1_im_o, dat_fft_2_re_o, dat_fft_2_im_o, dat_wn_adr_o,
    input  dat_out_vld_o, dat_out_re_o, dat_out_im_o, dat_out_idx_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/fft64_stage_seq.sv
// In-place radix-2 DIT sequencer: bit-reversed load, 6x32 butterflies through an
// external butterfly, natural-order dump with valid/ready.
module fft64_stage_seq #(
  parameter int unsigned DATA_WD = 16,
  parameter int unsigned PTS_LOG = 6
) (
  input logic              clk,
  input logic              rst,
  fft64_stage_seq_if.slave bus
);
  localparam int unsigned Pts  = 1 << PTS_LOG;
  localparam int unsigned StgW = $clog2(PTS_LOG);

  typedef enum logic [1:0] {StLoad, StCalc, StDump} state_e;

  state_e             state_q;
  logic [PTS_LOG-1:0] cnt_q;   // load sample n / dump bin idx
  logic [StgW-1:0]    stg_q;
  logic [PTS_LOG-2:0] bfy_q;
  logic               rdy_q, vld_q, busy_q, done_q;

  logic [DATA_WD-1:0] mem_re [Pts];
  logic [DATA_WD-1:0] mem_im [Pts];

  logic [PTS_LOG-1:0] span, pos, top, bot, wn_full;

  function automatic logic [PTS_LOG-1:0] bitrev(input logic [PTS_LOG-1:0] a);
    logic [PTS_LOG-1:0] r;
    for (int i = 0; i < PTS_LOG; i++) r[i] = a[PTS_LOG-1-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      stg_q   <= '0;
      bfy_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (bus.dat_inp_vld_i) begin
            cnt_q <= cnt_q + PTS_LOG'(1);
            if (&cnt_q) begin
              state_q <= StCalc;
              rdy_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        StCalc: begin
          bfy_q <= bfy_q + (PTS_LOG - 1)'(1);
          if (&bfy_q) begin
            if (stg_q == StgW'(PTS_LOG - 1)) begin
              stg_q   <= '0;
              state_q <= StDump;
              vld_q   <= 1'b1;
            end else begin
              stg_q <= stg_q + StgW'(1);
            end
          end
        end
        StDump: begin
          if (bus.dat_out_rdy_i) begin
            cnt_q <= cnt_q + PTS_LOG'(1);
            if (&cnt_q) begin
              state_q <= StLoad;
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // Butterfly addressing: top/bot are span apart inside blocks of 2*span.
  always_comb begin
    span    = PTS_LOG'(1) << stg_q;
    pos     = {1'b0, bfy_q} & (span - PTS_LOG'(1));
    top     = (({1'b0, bfy_q} >> stg_q) << (stg_q + StgW'(1))) + pos;
    bot     = top + span;
    wn_full = pos << (StgW'(PTS_LOG - 1) - stg_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StLoad && bus.dat_inp_vld_i) begin
        mem_re[bitrev(cnt_q)] <= bus.dat_inp_re_i;
        mem_im[bitrev(cnt_q)] <= bus.dat_inp_im_i;
      end else if (state_q == StCalc) begin
        mem_re[top] <= bus.dat_fft_1_re_i;
        mem_im[top] <= bus.dat_fft_1_im_i;
        mem_re[bot] <= bus.dat_fft_2_re_i;
        mem_im[bot] <= bus.dat_fft_2_im_i;
      end
    end
  end

  always_comb begin
    bus.dat_fft_1_re_o = '0;
    bus.dat_fft_1_im_o = '0;
    bus.dat_fft_2_re_o = '0;
    bus.dat_fft_2_im_o = '0;
    bus.dat_wn_adr_o   = '0;
    bus.dat_out_re_o   = '0;
    bus.dat_out_im_o   = '0;
    bus.dat_out_idx_o  = '0;
    if (state_q == StCalc) begin
      bus.dat_fft_1_re_o = mem_re[top];
      bus.dat_fft_1_im_o = mem_im[top];
      bus.dat_fft_2_re_o = mem_re[bot];
      bus.dat_fft_2_im_o = mem_im[bot];
      bus.dat_wn_adr_o   = wn_full[PTS_LOG-2:0];
    end
    if (state_q == StDump) begin
      bus.dat_out_re_o  = mem_re[cnt_q];
      bus.dat_out_im_o  = mem_im[cnt_q];
      bus.dat_out_idx_o = cnt_q;
    end
  end

  assign bus.dat_inp_rdy_o = rdy_q;
  assign bus.dat_out_vld_o = vld_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
endmodule

// File: tb/tb_fft64_stage_seq.sv
// Bench for fft64_stage_seq: models the external butterfly and checks each frame
// against a textbook iterative DIT FFT built on the same butterfly arithmetic.
module tb_fft64_stage_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft64_stage_seq_if #(.DATA_WD(16), .PTS_LOG(6)) bus ();
  fft64_stage_seq #(.DATA_WD(16), .PTS_LOG(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  int tw_re [32];
  int tw_im [32];
  int in_re [64], in_im [64];
  int exp_re [64], exp_im [64];
  int snap_re [6][64], snap_im [6][64];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done_o) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int wrap(input int v);
    return s16(v[15:0]);
  endfunction

  // b * W64^k with Q14 twiddles, rounded
  function automatic int mul_re(input int br, input int bi, input int k);
    return (br * tw_re[k] - bi * tw_im[k] + 8192) >>> 14;
  endfunction

  function automatic int mul_im(input int br, input int bi, input int k);
    return (br * tw_im[k] + bi * tw_re[k] + 8192) >>> 14;
  endfunction

  function automatic int bitrev6(input int n);
    int r = 0;
    for (int i = 0; i < 6; i++) if (n[i]) r = r | (1 << (5 - i));
    return r;
  endfunction

  initial begin
    for (int k = 0; k < 32; k++) begin
      tw_re[k] = int'(16384.0 * $cos(2.0 * 3.14159265358979 * k / 64.0));
      tw_im[k] = int'(-16384.0 * $sin(2.0 * 3.14159265358979 * k / 64.0));
    end
  end

  // External butterfly model
  int op1r, op1i, op2r, op2i, wk, pr, pim;
  always_comb begin
    op1r = s16(bus.dat_fft_1_re_o);
    op1i = s16(bus.dat_fft_1_im_o);
    op2r = s16(bus.dat_fft_2_re_o);
    op2i = s16(bus.dat_fft_2_im_o);
    wk   = int'(bus.dat_wn_adr_o);
    pr   = mul_re(op2r, op2i, wk);
    pim  = mul_im(op2r, op2i, wk);
    bus.dat_fft_1_re_i = 16'(op1r + pr);
    bus.dat_fft_1_im_i = 16'(op1i + pim);
    bus.dat_fft_2_re_i = 16'(op1r - pr);
    bus.dat_fft_2_im_i = 16'(op1i - pim);
  end

  // Reference: classic iterative DIT over an array; snap[s] is the array before stage s.
  task automatic ref_fft();
    int ar [64], ai [64];
    int len, half, k, qr, qi, tr, ti, b;
    for (int n = 0; n < 64; n++) begin
      ar[bitrev6(n)] = in_re[n];
      ai[bitrev6(n)] = in_im[n];
    end
    for (int st = 0; st < 6; st++) begin
      for (int n = 0; n < 64; n++) begin
        snap_re[st][n] = ar[n];
        snap_im[st][n] = ai[n];
      end
      len  = 2 << st;
      half = len / 2;
      for (int i = 0; i < 64; i += len) begin
        for (int j = 0; j < half; j++) begin
          k  = j * (64 / len);
          b  = i + j + half;
          qr = mul_re(ar[b], ai[b], k);
          qi = mul_im(ar[b], ai[b], k);
          tr = ar[i + j];
          ti = ai[i + j];
          ar[i + j] = wrap(tr + qr);
          ai[i + j] = wrap(ti + qi);
          ar[b]     = wrap(tr - qr);
          ai[b]     = wrap(ti - qi);
        end
      end
    end
    for (int n = 0; n < 64; n++) begin
      exp_re[n] = ar[n];
      exp_im[n] = ai[n];
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ":rdy_in"}, int'(bus.dat_inp_rdy_o), 1);
    check_eq({tag, ":vld_out"}, int'(bus.dat_out_vld_o), 0);
    check_eq({tag, ":busy"}, int'(bus.busy_o), 0);
    check_eq({tag, ":done"}, int'(bus.done_o), 0);
    check_eq({tag, ":op1re"}, s16(bus.dat_fft_1_re_o), 0);
    check_eq({tag, ":op2im"}, s16(bus.dat_fft_2_im_o), 0);
    check_eq({tag, ":wn"}, int'(bus.dat_wn_adr_o), 0);
    check_eq({tag, ":out_re"}, s16(bus.dat_out_re_o), 0);
    check_eq({tag, ":out_idx"}, int'(bus.dat_out_idx_o), 0);
  endtask

  task automatic check_ops(input string tag, input int s, input int t, input int b, input int w);
    check_eq({tag, ":top_re"}, s16(bus.dat_fft_1_re_o), snap_re[s][t]);
    check_eq({tag, ":top_im"}, s16(bus.dat_fft_1_im_o), snap_im[s][t]);
    check_eq({tag, ":bot_re"}, s16(bus.dat_fft_2_re_o), snap_re[s][b]);
    check_eq({tag, ":bot_im"}, s16(bus.dat_fft_2_im_o), snap_im[s][b]);
    check_eq({tag, ":wn"}, int'(bus.dat_wn_adr_o), w);
  endtask

  // Called at a negedge in LOAD; returns at a negedge.
  task automatic run_frame(input string name, input bit gaps, input int stall_at,
                           input bit op_chk, input bit time_chk, input int abort_at);
    int n, guard, c, t0, idx, stall;
    bit tog;
    ref_fft();
    n = 0; guard = 0; tog = 1'b0; t0 = -1;
    while (n < 64 && guard < 1000) begin
      tog = ~tog;
      bus.dat_inp_vld_i = gaps ? tog : 1'b1;
      bus.dat_inp_re_i  = 16'(in_re[n]);
      bus.dat_inp_im_i  = 16'(in_im[n]);
      if (bus.dat_inp_vld_i && bus.dat_inp_rdy_o) begin
        if (t0 < 0) t0 = cyc;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    check_eq({name, ":loaded"}, n, 64);
    // Keep offering data during CALC; none of it may be taken.
    bus.dat_inp_vld_i = 1'b1;
    bus.dat_inp_re_i  = 16'($urandom);
    check_eq({name, ":rdy_in_calc"}, int'(bus.dat_inp_rdy_o), 0);
    check_eq({name, ":busy_calc"}, int'(bus.busy_o), 1);
    c = 0;
    while (!bus.dat_out_vld_o && c < 300) begin
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_idle({name, ":after_rst"});
        @(negedge clk);
        check_idle({name, ":in_rst"});
        rst = 1'b0;
        bus.dat_inp_vld_i = 1'b0;
        return;
      end
      if (op_chk) begin
        if (c == 0)   check_ops({name, ":c0"}, 0, 0, 1, 0);
        if (c == 69)  check_ops({name, ":s2b5"}, 2, 9, 13, 8);
        if (c == 160) check_ops({name, ":s5b0"}, 5, 0, 32, 0);
        if (c == 161) check_ops({name, ":s5b1"}, 5, 1, 33, 1);
      end
      @(negedge clk);
      c++;
    end
    bus.dat_inp_vld_i = 1'b0;
    check_eq({name, ":calc_cycles"}, c, 192);
    idx = 0; stall = 0; guard = 0;
    while (idx < 64 && guard < 500) begin
      check_eq({name, ":vld"}, int'(bus.dat_out_vld_o), 1);
      check_eq({name, ":idx"}, int'(bus.dat_out_idx_o), idx);
      check_eq({name, ":re"}, s16(bus.dat_out_re_o), exp_re[idx]);
      check_eq({name, ":im"}, s16(bus.dat_out_im_o), exp_im[idx]);
      check_eq({name, ":done_early"}, int'(bus.done_o), 0);
      if (idx == stall_at && stall < 5) begin
        bus.dat_out_rdy_i = 1'b0;
        stall++;
      end else begin
        bus.dat_out_rdy_i = 1'b1;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    bus.dat_out_rdy_i = 1'b1;
    check_eq({name, ":dumped"}, idx, 64);
    check_eq({name, ":done"}, int'(bus.done_o), 1);
    check_eq({name, ":vld_end"}, int'(bus.dat_out_vld_o), 0);
    check_eq({name, ":rdy_in_next"}, int'(bus.dat_inp_rdy_o), 1);
    check_eq({name, ":busy_end"}, int'(bus.busy_o), 0);
    if (time_chk) check_eq({name, ":latency"}, cyc - t0, 320);
    @(negedge clk);
    check_eq({name, ":done_pulse"}, int'(bus.done_o), 0);
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 64; n++) begin
      in_re[n] = (n == 0) ? 256 : 0;
      in_im[n] = 0;
    end
  endtask

  task automatic set_random();
    for (int n = 0; n < 64; n++) begin
      in_re[n] = int'($urandom_range(200)) - 100;
      in_im[n] = int'($urandom_range(200)) - 100;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.dat_inp_vld_i = 1'b0;
    bus.dat_inp_re_i  = '0;
    bus.dat_inp_im_i  = '0;
    bus.dat_out_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    set_impulse();
    run_frame("impulse", 1'b0, -1, 1'b0, 1'b1, -1);
    for (int n = 0; n < 64; n++) begin
      in_re[n] = 256;
      in_im[n] = 0;
    end
    run_frame("dc", 1'b0, -1, 1'b0, 1'b1, -1);
    check_eq("dc:x0", exp_re[0], 16384);
    for (int n = 0; n < 64; n++) begin
      in_re[n] = n;
      in_im[n] = 0;
    end
    run_frame("ramp", 1'b0, -1, 1'b1, 1'b0, -1);
    set_random();
    run_frame("rnd", 1'b0, -1, 1'b1, 1'b0, -1);
    run_frame("rnd_gap_stall", 1'b1, 10, 1'b0, 1'b0, -1);
    set_random();
    run_frame("rnd_abort", 1'b0, -1, 1'b0, 1'b0, 100);
    @(negedge clk);
    set_impulse();
    run_frame("impulse2", 1'b0, -1, 1'b0, 1'b1, -1);
    check_eq("done_pulses", done_cnt, 6);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule
